// File: rtl/inst_fetch_if.sv
// Fetch-unit bus: control from the ROB, the memory fetch handshake and the
// instruction-queue push. The fetch unit takes the master side.
interface inst_fetch_if;
    logic        rdy_in;
    logic        rob_flush_in;
    logic [31:0] rob_target_pc_in;
    logic        mem_rdy_in;
    logic        mem_en_out;
    logic [31:0] mem_pc_out;
    logic        mem_en_in;
    logic [31:0] mem_inst_in;
    logic        iq_full_in;
    logic        iq_en_out;
    logic [31:0] iq_inst_out;
    logic [31:0] iq_pc_out;

    modport master (
        input  rdy_in, rob_flush_in, rob_target_pc_in,
        input  mem_rdy_in, mem_en_in, mem_inst_in, iq_full_in,
        output mem_en_out, mem_pc_out, iq_en_out, iq_inst_out, iq_pc_out
    );

    modport slave (
        output rdy_in, rob_flush_in, rob_target_pc_in,
        output mem_rdy_in, mem_en_in, mem_inst_in, iq_full_in,
        input  mem_en_out, mem_pc_out, iq_en_out, iq_inst_out, iq_pc_out
    );
endinterface

// File: rtl/inst_fetch.sv
// Instruction fetch with a 16-entry direct-mapped icache. Hits issue one
// instruction per cycle; misses fill from memory, then reissue as a hit.
module inst_fetch (
    input  logic         clk_in,
    input  logic         rst_in,
    inst_fetch_if.master bus
);
    localparam logic [31:0] PC_STEP = 32'd4;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [15:0] r_valid;
    logic [25:0] r_tag  [16];
    logic [31:0] r_data [16];
    logic        r_mem_en_q;
    logic        r_mem_en;
    logic [31:0] r_mem_pc;
    logic        r_iq_en;
    logic [31:0] r_iq_inst;
    logic [31:0] r_iq_pc;

    logic [3:0]  w_idx;
    logic [25:0] w_tag;
    logic        w_hit;
    logic        w_rise;
    logic        w_flush;
    logic        w_issue;
    logic        w_request;
    logic        w_accept;

    assign w_idx   = r_pc[5:2];
    assign w_tag   = r_pc[31:6];
    assign w_hit   = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    // Only a fresh rising edge of the level-style valid counts as a response.
    assign w_rise  = bus.mem_en_in && !r_mem_en_q;
    assign w_flush = bus.rdy_in && bus.rob_flush_in;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        w_next_state = r_state;
        w_issue      = 1'b0;
        w_request    = 1'b0;
        w_accept     = 1'b0;
        if (w_flush) begin
            w_next_state = IDLE;
        end else if (bus.rdy_in) begin
            case (r_state)
                IDLE: begin
                    if (w_hit) begin
                        w_issue = !bus.iq_full_in;
                    end else if (bus.mem_rdy_in) begin
                        w_request    = 1'b1;
                        w_next_state = WAIT;
                    end
                end
                WAIT: begin
                    if (w_rise) begin
                        w_accept     = 1'b1;
                        w_next_state = IDLE;
                    end
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_pc       <= '0;
            r_mem_en_q <= 1'b0;
            r_mem_en   <= 1'b0;
            r_mem_pc   <= '0;
            r_iq_en    <= 1'b0;
            r_iq_inst  <= '0;
            r_iq_pc    <= '0;
        end else if (bus.rdy_in) begin
            r_mem_en_q <= bus.mem_en_in;
            r_iq_en    <= w_issue;
            if (w_flush) begin
                r_pc     <= bus.rob_target_pc_in;
                r_mem_en <= 1'b0;
            end else begin
                if (w_issue) begin
                    r_iq_inst <= r_data[w_idx];
                    r_iq_pc   <= r_pc;
                    r_pc      <= r_pc + PC_STEP;
                end
                if (w_request) begin
                    r_mem_en <= 1'b1;
                    r_mem_pc <= r_pc;
                end
                if (w_accept) begin
                    r_mem_en <= 1'b0;
                end
            end
        end else begin
            // Stalled: everything holds, but a held valid would re-issue.
            r_iq_en <= 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_valid <= '0;
        end else if (w_accept) begin
            r_valid[w_idx] <= 1'b1;
        end
    end

    // NOTE: tag/data arrays carry no reset; the valid bits alone decide whether an entry is usable.
    always_ff @(posedge clk_in) begin
        if (w_accept && !rst_in) begin
            r_tag[w_idx]  <= w_tag;
            r_data[w_idx] <= bus.mem_inst_in;
        end
    end

    assign bus.mem_en_out  = r_mem_en;
    assign bus.mem_pc_out  = r_mem_pc;
    assign bus.iq_en_out   = r_iq_en;
    assign bus.iq_inst_out = r_iq_inst;
    assign bus.iq_pc_out   = r_iq_pc;
endmodule

// File: tb/tb_inst_fetch.sv
// Testbench for inst_fetch: directed scenarios followed by randomized traffic
// checked against a transaction-level model of the fetch/cache behaviour.
module tb_inst_fetch;
    logic clk_in = 1'b0;
    logic rst_in;
    int   total = 0;
    int   bad   = 0;

    inst_fetch_if bus();

    inst_fetch dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired got=running want=finished");
        $fatal(1, "watchdog");
    end

    // Reference model state: cache kept as word addresses per slot.
    logic [31:0] m_pc, m_mem_pc, m_iq_inst, m_iq_pc;
    bit          m_wait, m_q, m_mem_en, m_iq_en;
    bit          m_v    [16];
    logic [31:0] m_word [16];
    logic [31:0] m_data [16];

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic model_step();
        bit prev;
        int slot;
        if (rst_in) begin
            m_pc = 0; m_wait = 0; m_q = 0; m_mem_en = 0; m_mem_pc = 0;
            m_iq_en = 0; m_iq_inst = 0; m_iq_pc = 0;
            for (int k = 0; k < 16; k++) m_v[k] = 0;
        end else if (!bus.rdy_in) begin
            m_iq_en = 0;
        end else begin
            prev    = m_q;
            m_q     = bus.mem_en_in;
            m_iq_en = 0;
            slot    = int'((m_pc / 4) % 16);
            if (bus.rob_flush_in) begin
                m_pc = bus.rob_target_pc_in; m_wait = 0; m_mem_en = 0;
            end else if (m_wait) begin
                if (bus.mem_en_in && !prev) begin
                    m_v[slot] = 1; m_word[slot] = m_pc / 4; m_data[slot] = bus.mem_inst_in;
                    m_mem_en = 0; m_wait = 0;
                end
            end else if (m_v[slot] && m_word[slot] == m_pc / 4) begin
                if (!bus.iq_full_in) begin
                    m_iq_en = 1; m_iq_inst = m_data[slot]; m_iq_pc = m_pc; m_pc = m_pc + 4;
                end
            end else if (bus.mem_rdy_in) begin
                m_mem_en = 1; m_mem_pc = m_pc; m_wait = 1;
            end
        end
    endtask

    task automatic test_reset();
        rst_in = 1; bus.rdy_in = 1; bus.rob_flush_in = 1; bus.rob_target_pc_in = 32'h1234;
        bus.mem_rdy_in = 1; bus.mem_en_in = 1; bus.mem_inst_in = 32'hFFFF_FFFF; bus.iq_full_in = 0;
        tick();
        total++; if (bus.mem_en_out !== 1'b0) begin bad++; $display("FAIL reset_mem_en got=%0b want=0", bus.mem_en_out); end
        total++; if (bus.mem_pc_out !== 32'h0) begin bad++; $display("FAIL reset_mem_pc got=%h want=0", bus.mem_pc_out); end
        total++; if (bus.iq_en_out !== 1'b0) begin bad++; $display("FAIL reset_iq_en got=%0b want=0", bus.iq_en_out); end
        total++; if (bus.iq_inst_out !== 32'h0) begin bad++; $display("FAIL reset_iq_inst got=%h want=0", bus.iq_inst_out); end
        total++; if (bus.iq_pc_out !== 32'h0) begin bad++; $display("FAIL reset_iq_pc got=%h want=0", bus.iq_pc_out); end
        total++; if (dut.r_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h want=0", dut.r_pc); end
        bus.rob_flush_in = 0; bus.mem_rdy_in = 0; bus.mem_en_in = 0;
        tick();
    endtask

    task automatic test_cold_miss();
        rst_in = 0; bus.mem_rdy_in = 1;
        tick();
        total++; if (bus.mem_en_out !== 1'b1) begin bad++; $display("FAIL cold_req got=%0b want=1", bus.mem_en_out); end
        total++; if (bus.mem_pc_out !== 32'h0) begin bad++; $display("FAIL cold_req_pc got=%h want=0", bus.mem_pc_out); end
        bus.mem_rdy_in = 0;
        tick();
        total++; if (bus.mem_en_out !== 1'b1) begin bad++; $display("FAIL cold_hold got=%0b want=1", bus.mem_en_out); end
        bus.mem_en_in = 1; bus.mem_inst_in = 32'h0000_0013;
        tick();
        total++; if (bus.mem_en_out !== 1'b0) begin bad++; $display("FAIL cold_accept got=%0b want=0", bus.mem_en_out); end
        total++; if (bus.iq_en_out !== 1'b0) begin bad++; $display("FAIL cold_no_direct got=%0b want=0", bus.iq_en_out); end
        bus.mem_en_in = 0;
        tick();
        total++; if (bus.iq_en_out !== 1'b1) begin bad++; $display("FAIL cold_issue got=%0b want=1", bus.iq_en_out); end
        total++; if (bus.iq_inst_out !== 32'h13) begin bad++; $display("FAIL cold_inst got=%h want=00000013", bus.iq_inst_out); end
        total++; if (bus.iq_pc_out !== 32'h0) begin bad++; $display("FAIL cold_iq_pc got=%h want=0", bus.iq_pc_out); end
        total++; if (dut.r_pc !== 32'h4) begin bad++; $display("FAIL cold_pc got=%h want=4", dut.r_pc); end
        tick();
        total++; if (bus.iq_en_out !== 1'b0) begin bad++; $display("FAIL cold_pulse got=%0b want=0", bus.iq_en_out); end
    endtask

    task automatic test_flush_hit();
        bus.rob_flush_in = 1; bus.rob_target_pc_in = 32'h0;
        tick();
        total++; if (bus.iq_en_out !== 1'b0) begin bad++; $display("FAIL fhit_flush_iq got=%0b want=0", bus.iq_en_out); end
        total++; if (dut.r_pc !== 32'h0) begin bad++; $display("FAIL fhit_pc got=%h want=0", dut.r_pc); end
        bus.rob_flush_in = 0;
        tick();
        total++; if (bus.iq_en_out !== 1'b1 || bus.iq_pc_out !== 32'h0) begin bad++; $display("FAIL fhit_issue got=%0b/%h want=1/0", bus.iq_en_out, bus.iq_pc_out); end
        total++; if (bus.mem_en_out !== 1'b0) begin bad++; $display("FAIL fhit_no_req got=%0b want=0", bus.mem_en_out); end
    endtask

    task automatic test_backpressure();
        bus.mem_rdy_in = 1;
        tick();
        total++; if (bus.mem_en_out !== 1'b1 || bus.mem_pc_out !== 32'h4) begin bad++; $display("FAIL bp_req got=%0b/%h want=1/4", bus.mem_en_out, bus.mem_pc_out); end
        bus.mem_rdy_in = 0; bus.mem_en_in = 1; bus.mem_inst_in = 32'hA5A5_0004;
        tick();
        bus.mem_en_in = 0; bus.iq_full_in = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (bus.iq_en_out !== 1'b0 || dut.r_pc !== 32'h4) begin bad++; $display("FAIL bp_hold%0d got=%0b/%h want=0/4", i, bus.iq_en_out, dut.r_pc); end
        end
        bus.iq_full_in = 0;
        tick();
        total++; if (bus.iq_en_out !== 1'b1 || bus.iq_pc_out !== 32'h4) begin bad++; $display("FAIL bp_issue got=%0b/%h want=1/4", bus.iq_en_out, bus.iq_pc_out); end
        total++; if (bus.iq_inst_out !== 32'hA5A5_0004) begin bad++; $display("FAIL bp_inst got=%h want=a5a50004", bus.iq_inst_out); end
        tick();
        total++; if (bus.iq_en_out !== 1'b0) begin bad++; $display("FAIL bp_single got=%0b want=0", bus.iq_en_out); end
    endtask

    task automatic test_stale_valid();
        bus.mem_en_in = 1; bus.mem_rdy_in = 1;
        tick();
        total++; if (bus.mem_en_out !== 1'b1 || bus.mem_pc_out !== 32'h8) begin bad++; $display("FAIL stale_req got=%0b/%h want=1/8", bus.mem_en_out, bus.mem_pc_out); end
        bus.mem_rdy_in = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (bus.mem_en_out !== 1'b1) begin bad++; $display("FAIL stale_ignored%0d got=%0b want=1", i, bus.mem_en_out); end
        end
        bus.mem_en_in = 0;
        tick();
        total++; if (bus.mem_en_out !== 1'b1) begin bad++; $display("FAIL stale_low got=%0b want=1", bus.mem_en_out); end
        bus.mem_en_in = 1; bus.mem_inst_in = 32'hDEAD_BEEF;
        tick();
        total++; if (bus.mem_en_out !== 1'b0) begin bad++; $display("FAIL stale_accept got=%0b want=0", bus.mem_en_out); end
        bus.mem_en_in = 0;
        tick();
        total++; if (bus.iq_en_out !== 1'b1 || bus.iq_inst_out !== 32'hDEAD_BEEF || bus.iq_pc_out !== 32'h8) begin
            bad++; $display("FAIL stale_fill got=%0b/%h/%h want=1/deadbeef/8", bus.iq_en_out, bus.iq_inst_out, bus.iq_pc_out); end
    endtask

    task automatic test_flush_in_wait();
        bus.mem_rdy_in = 1;
        tick();
        total++; if (bus.mem_en_out !== 1'b1 || bus.mem_pc_out !== 32'hC) begin bad++; $display("FAIL fw_req got=%0b/%h want=1/c", bus.mem_en_out, bus.mem_pc_out); end
        bus.mem_rdy_in = 0; bus.rob_flush_in = 1; bus.rob_target_pc_in = 32'h100;
        tick();
        total++; if (bus.mem_en_out !== 1'b0 || dut.r_pc !== 32'h100) begin bad++; $display("FAIL fw_flush got=%0b/%h want=0/100", bus.mem_en_out, dut.r_pc); end
        bus.rob_flush_in = 0; bus.mem_en_in = 1; bus.mem_inst_in = 32'h55;
        tick();
        bus.mem_en_in = 0; bus.rob_flush_in = 1; bus.rob_target_pc_in = 32'hC;
        tick();
        bus.rob_flush_in = 0;
        tick();
        total++; if (bus.iq_en_out !== 1'b0) begin bad++; $display("FAIL fw_late_resp got=%0b want=0", bus.iq_en_out); end
        // Flush and response on the same edge: flush wins, nothing is written.
        bus.mem_rdy_in = 1;
        tick();
        bus.mem_rdy_in = 0; bus.rob_flush_in = 1; bus.mem_en_in = 1; bus.mem_inst_in = 32'h77;
        tick();
        total++; if (bus.mem_en_out !== 1'b0) begin bad++; $display("FAIL fw_same_edge got=%0b want=0", bus.mem_en_out); end
        bus.rob_flush_in = 0; bus.mem_en_in = 0;
        tick();
        total++; if (bus.iq_en_out !== 1'b0) begin bad++; $display("FAIL fw_same_nowrite got=%0b want=0", bus.iq_en_out); end
    endtask

    task automatic test_conflict();
        bus.rob_flush_in = 1; bus.rob_target_pc_in = 32'h40;
        tick();
        bus.rob_flush_in = 0; bus.mem_rdy_in = 1;
        tick();
        total++; if (bus.mem_en_out !== 1'b1 || bus.mem_pc_out !== 32'h40) begin bad++; $display("FAIL conf_req got=%0b/%h want=1/40", bus.mem_en_out, bus.mem_pc_out); end
        bus.mem_rdy_in = 0; bus.mem_en_in = 1; bus.mem_inst_in = 32'h4040_4040;
        tick();
        bus.mem_en_in = 0;
        tick();
        total++; if (bus.iq_en_out !== 1'b1 || bus.iq_pc_out !== 32'h40 || bus.iq_inst_out !== 32'h4040_4040) begin
            bad++; $display("FAIL conf_fill got=%0b/%h/%h want=1/40/40404040", bus.iq_en_out, bus.iq_pc_out, bus.iq_inst_out); end
        bus.rob_flush_in = 1; bus.rob_target_pc_in = 32'h0;
        tick();
        bus.rob_flush_in = 0; bus.mem_rdy_in = 1;
        tick();
        total++; if (bus.mem_en_out !== 1'b1 || bus.mem_pc_out !== 32'h0 || bus.iq_en_out !== 1'b0) begin
            bad++; $display("FAIL conf_evict got=%0b/%h/%0b want=1/0/0", bus.mem_en_out, bus.mem_pc_out, bus.iq_en_out); end
        bus.mem_rdy_in = 0; bus.mem_en_in = 1; bus.mem_inst_in = 32'h13;
        tick();
        bus.mem_en_in = 0;
        tick();
        total++; if (bus.iq_en_out !== 1'b1 || bus.iq_pc_out !== 32'h0) begin bad++; $display("FAIL conf_refill got=%0b/%h want=1/0", bus.iq_en_out, bus.iq_pc_out); end
    endtask

    task automatic test_stall();
        bus.rdy_in = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (bus.iq_en_out !== 1'b0 || dut.r_pc !== 32'h4) begin bad++; $display("FAIL stall%0d got=%0b/%h want=0/4", i, bus.iq_en_out, dut.r_pc); end
        end
        bus.rob_flush_in = 1; bus.rob_target_pc_in = 32'h200;
        tick();
        total++; if (dut.r_pc !== 32'h4) begin bad++; $display("FAIL stall_flush got=%h want=4", dut.r_pc); end
        bus.rob_flush_in = 0; bus.rdy_in = 1;
        tick();
        total++; if (bus.iq_en_out !== 1'b1 || bus.iq_pc_out !== 32'h4) begin bad++; $display("FAIL stall_resume got=%0b/%h want=1/4", bus.iq_en_out, bus.iq_pc_out); end
    endtask

    task automatic test_reset_in_wait();
        bus.rob_flush_in = 1; bus.rob_target_pc_in = 32'h80;
        tick();
        bus.rob_flush_in = 0; bus.mem_rdy_in = 1;
        tick();
        total++; if (bus.mem_en_out !== 1'b1 || bus.mem_pc_out !== 32'h80) begin bad++; $display("FAIL rw_req got=%0b/%h want=1/80", bus.mem_en_out, bus.mem_pc_out); end
        bus.mem_rdy_in = 0; rst_in = 1;
        tick();
        total++; if (bus.mem_en_out !== 1'b0 || dut.r_pc !== 32'h0) begin bad++; $display("FAIL rw_abandon got=%0b/%h want=0/0", bus.mem_en_out, dut.r_pc); end
        rst_in = 0;
        tick();
        total++; if (bus.iq_en_out !== 1'b0) begin bad++; $display("FAIL rw_cache_cleared got=%0b want=0", bus.iq_en_out); end
    endtask

    task automatic test_random();
        rst_in = 1;
        model_step();
        tick();
        for (int c = 0; c < 3000; c++) begin
            rst_in               = ($urandom_range(0, 199) == 0);
            bus.rdy_in           = ($urandom_range(0, 9) != 0);
            bus.rob_flush_in     = ($urandom_range(0, 24) == 0);
            bus.rob_target_pc_in = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF8
                                 : {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            bus.mem_rdy_in       = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) bus.mem_en_in = !bus.mem_en_in;
            bus.mem_inst_in      = $urandom;
            bus.iq_full_in       = ($urandom_range(0, 3) == 0);
            model_step();
            tick();
            total++;
            if (bus.mem_en_out !== m_mem_en || bus.mem_pc_out !== m_mem_pc || bus.iq_en_out !== m_iq_en
                || bus.iq_inst_out !== m_iq_inst || bus.iq_pc_out !== m_iq_pc) begin
                bad++;
                $display("FAIL rand cyc=%0d got=%0b/%h/%0b/%h/%h want=%0b/%h/%0b/%h/%h", c,
                         bus.mem_en_out, bus.mem_pc_out, bus.iq_en_out, bus.iq_inst_out, bus.iq_pc_out,
                         m_mem_en, m_mem_pc, m_iq_en, m_iq_inst, m_iq_pc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_flush_hit();
        test_backpressure();
        test_stale_valid();
        test_flush_in_wait();
        test_conflict();
        test_stall();
        test_reset_in_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be synchronous and active-high.
REQ-002 Ports (name direction width meaning):
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- rdy_in  in  1  global enable; low = stall
- rob_flush_in  in  1  pipeline flush
- rob_target_pc_in  in  32  redirect PC on flush
- mem_rdy_in  in  1  memory bus arbiter grants/accepts an IF request
- mem_en_out  out  1  IF fetch request, held until response accepted
- mem_pc_out  out  32  fetch byte address
- mem_en_in  in  1  fetch data valid (level, may stay high after completion)
- mem_inst_in  in  32  fetched instruction
- iq_full_in  in  1  instruction queue cannot accept
- iq_en_out  out  1  one-cycle instruction-valid pulse
- iq_inst_out  out  32  instruction to queue
- iq_pc_out  out  32  PC of iq_inst_out

Function
REQ-003 The block SHALL keep a 32-bit pc register and a 16-entry direct-mapped icache: index = pc[5:2], tag = pc[31:6], 32-bit data, 1 valid bit per entry.
REQ-004 The FSM SHALL have states IDLE and WAIT.
REQ-005 Hit = valid[pc[5:2]] && tag match.
REQ-006 In IDLE on a hit with iq_full_in=0, the next edge SHALL set iq_en_out=1, iq_inst_out=cached data, iq_pc_out=pc, and pc<=pc+4 (mod 2^32); state stays IDLE.
REQ-007 In IDLE on a hit with iq_full_in=1, the block SHALL emit nothing; pc and state SHALL hold.
REQ-008 In IDLE on a miss with mem_rdy_in=1, the next edge SHALL set mem_en_out=1, mem_pc_out=pc, and state=WAIT; with mem_rdy_in=0 it SHALL stay IDLE with no request.
REQ-009 In WAIT, mem_en_out and mem_pc_out SHALL hold steady.
REQ-010 A response SHALL be accepted only on a rising edge of mem_en_in (mem_en_in=1 and the registered prior sample mem_en_q=0); stale high levels SHALL be ignored.
REQ-011 On acceptance, the block SHALL write the cache entry (data, tag, valid=1), drive mem_en_out=0, and set state=IDLE; the instruction SHALL NOT be emitted directly, so the following IDLE cycle hits (miss-to-issue latency = response edge + 1 cycle).
REQ-012 iq_en_out SHALL be 0 on every cycle not covered by REQ-006.
REQ-013 Flush (rdy_in=1, rob_flush_in=1) SHALL take priority over all else: pc<=rob_target_pc_in, state=IDLE, mem_en_out=0, iq_en_out=0; the cache SHALL be retained; an in-flight response SHALL be discarded.
REQ-014 mem_en_q SHALL sample mem_en_in every cycle rdy_in=1, including flush cycles.
REQ-015 When rdy_in=0, all state SHALL hold except iq_en_out, which SHALL be forced to 0 so that no duplicate issue occurs.
REQ-016 A flush and a response on the same edge SHALL give flush only, with no cache write.

Reset
REQ-017 When rst_in=1, the block SHALL set pc=0, state=IDLE, all valid bits=0, mem_en_out=0, mem_pc_out=0, iq_en_out=0, iq_inst_out=0, iq_pc_out=0, mem_en_q=0; reset SHALL override rdy_in and flush.
REQ-018 Reset during WAIT SHALL abandon the request at the next edge.

Verification
REQ-019 Cold miss: release reset, mem_rdy_in=1 -> mem_en_out=1, mem_pc_out=0x0; pulse mem_en_in with 0x00000013 -> mem_en_out=0, and the next cycle iq_en_out=1, iq_inst_out=0x00000013, iq_pc_out=0x0, pc=0x4.
REQ-020 Flush hit: after 0x0 is cached, flush to 0x0 -> iq_en_out=1 with iq_pc_out=0x0 one cycle after the flush cycle, and mem_en_out never asserted.
REQ-021 Backpressure: hit at 0x4 with iq_full_in=1 for 3 cycles -> no iq_en_out, pc=0x4; deassert -> a single iq_en_out pulse with iq_pc_out=0x4.
REQ-022 Stale valid: mem_en_in held high entering WAIT -> no acceptance; drop it for 1 cycle, then raise it with 0xDEADBEEF -> entry filled with 0xDEADBEEF.
REQ-023 Flush in WAIT to 0x100 -> next cycle mem_en_out=0, pc=0x100; a later mem_en_in pulse SHALL cause no cache write.
REQ-024 Conflict: 0x0 cached, fetch 0x40 (same index, different tag) -> miss and request 0x40; after fill, a refetch of 0x0 misses again.
